mem_access_unit: RTL

- Sits between the MEM pipeline stage and the word-only data memory.
- Turns CPU load/store requests of byte, halfword or word size into word accesses: lane extraction with sign/zero extension for loads, read-modify-write for sub-word stores.
- Checks alignment and stalls the pipeline via req_ready while a transaction is in flight.
- Memory side: combinational read (mem_rdata valid while mem_read=1, same cycle); write committed on falling clk edge while mem_write=1.

---
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Bridges MEM-stage load/store requests of byte/half/word size onto a
//   word-only data memory. Loads select and extend one lane of the memory
//   word. Sub-word stores run a read-modify-write. Word stores write directly.
//   Misaligned or reserved-size requests complete with resp_err and never
//   touch memory. One transaction is in flight at a time, and req_ready is
//   high only in IDLE.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (accepted when both are high)
//   req_write                1 = store, 0 = load
//   req_size                 00 byte, 01 half, 10 word, 11 reserved
//   req_signed               loads: sign-extend (1) or zero-extend (0)
//   req_addr                 byte address
//   req_wdata                right-justified store data
//   resp_valid               one-cycle completion pulse
//   resp_err                 misaligned or reserved size (with resp_valid)
//   resp_rdata               extended load data, 0 for stores and errors
//   mem_read / mem_write     memory strobes, decoded from state only
//   mem_addr                 word-aligned address, held for the transaction
//   mem_wdata                full (merged) write word
//   mem_rdata                combinational memory read data
module mem_access_unit #(
    parameter int BIG_ENDIAN = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;

    // Request fields kept for the whole transaction.
    typedef struct packed {
        logic [1:0]  off;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
    } req_t;

    state_t state, state_nxt;
    req_t   cap;

    logic        accept;
    logic        req_err;
    logic [4:0]  lane_lo;
    logic [31:0] lane_data;
    logic [31:0] lane_mask;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign mem_read  = (state == LOAD) || (state == RMW_RD);
    assign mem_write = (state == WRITE);

    assign req_err = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Bit position of the lowest bit of the addressed lane. In big-endian
    // order the lowest byte address holds the most significant lane, so the
    // offset is inverted.
    always_comb begin
        lane_lo = 5'd0;
        case (cap.size)
            2'b00:   lane_lo = (BIG_ENDIAN != 0) ? {~cap.off, 3'b000} : {cap.off, 3'b000};
            2'b01:   lane_lo = (BIG_ENDIAN != 0) ? {~cap.off[1], 4'b0000} : {cap.off[1], 4'b0000};
            default: lane_lo = 5'd0;
        endcase
    end

    assign lane_data = mem_rdata >> lane_lo;
    assign lane_mask = ((cap.size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_lo;
    assign merged    = (mem_rdata & ~lane_mask) | ((cap.wdata << lane_lo) & lane_mask);

    always_comb begin
        load_ext = lane_data;
        case (cap.size)
            2'b00:   load_ext = {{24{cap.sgn & lane_data[7]}},  lane_data[7:0]};
            2'b01:   load_ext = {{16{cap.sgn & lane_data[15]}}, lane_data[15:0]};
            default: load_ext = lane_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)               state_nxt = DONE;
                    else if (!req_write)       state_nxt = LOAD;
                    else if (req_size == 2'b10) state_nxt = WRITE;
                    else                       state_nxt = RMW_RD;
                end
            end
            LOAD:    state_nxt = DONE;
            RMW_RD:  state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            // resp_* are live only during the single DONE cycle.
            resp_valid <= (state_nxt == DONE);
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            if (accept) begin
                cap      <= '{off: req_addr[1:0], size: req_size, sgn: req_signed, wdata: req_wdata};
                mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                resp_err <= req_err;
                if (req_write && (req_size == 2'b10) && !req_err)
                    mem_wdata <= req_wdata;
            end
            if (state == LOAD)
                resp_rdata <= load_ext;
            if (state == RMW_RD)
                mem_wdata <= merged;
        end
    end

endmodule
